mul_div_sequencer: RTL

- Multi-cycle iterative multiply/divide unit for the execute stage. Runs alongside the single-cycle ALU and covers LEGv8 MUL, SMULH, UMULH, SDIV and UDIV.
- Control holds the PC and register write-back while busy is high. It captures result when done pulses.
- Multiply is shift-add, one bit per cycle. Divide is restoring, one quotient bit per cycle. Signed operations run on magnitudes and apply a sign fix at the end.

---
 rtl/mul_div_if.sv | 24 ++
 rtl/mul_div_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mul_div_if.sv
// Operand/result bundle between the execute-stage control and the iterative
// multiply/divide sequencer.
interface mul_div_if #(
   parameter int WIDTH = 64
);
   logic             start;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             div_by_zero;

   modport master (
      output start, op, a, b,
      input  busy, done, result, div_by_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, done, result, div_by_zero
   );
endinterface

// File: rtl/mul_div_sequencer.sv
// Iterative shift-add multiplier / restoring divider covering MUL, SMULH,
// UMULH, SDIV and UDIV; signed ops run on magnitudes with a final sign fix.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   S_IDLE | waiting for start
//   S_RUN  | one multiply/divide bit per cycle, WIDTH cycles
//   S_FIX  | sign fix and result select, result registered on exit
//   S_DONE | one-cycle done pulse; start here chains the next operation
module mul_div_sequencer #(
   parameter int WIDTH = 64
) (
   input logic    clk,
   input logic    reset,
   mul_div_if.slave bus
);

   localparam int CNT_W = $clog2(WIDTH + 1);

   localparam logic [2:0] OP_MUL   = 3'b000;
   localparam logic [2:0] OP_SMULH = 3'b001;
   localparam logic [2:0] OP_UMULH = 3'b010;
   localparam logic [2:0] OP_SDIV  = 3'b011;
   localparam logic [2:0] OP_UDIV  = 3'b100;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t state, state_nxt;

   logic [2:0]         op_q;
   logic               neg_q;
   logic [CNT_W-1:0]   cnt;
   logic [2*WIDTH-1:0] mcand;
   logic [2*WIDTH-1:0] prod;
   logic [WIDTH-1:0]   mplier;
   logic [WIDTH-1:0]   rem;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   dvsr;
   logic [WIDTH-1:0]   result_q;
   logic               dbz_q;

   logic               is_signed_op;
   logic               is_div_op;
   logic               op_illegal;
   logic               div_zero;
   logic               accept;
   logic               short_path;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH:0]     trial;
   logic [WIDTH-1:0]   smulh_hi;
   logic [WIDTH-1:0]   fix_result;

   always_comb begin
      is_signed_op = (bus.op == OP_SMULH) || (bus.op == OP_SDIV);
      is_div_op    = (bus.op == OP_SDIV) || (bus.op == OP_UDIV);
      op_illegal   = (bus.op > OP_UDIV);
      div_zero     = is_div_op && (bus.b == '0);
      a_mag        = (is_signed_op && bus.a[WIDTH-1]) ? -bus.a : bus.a;
      b_mag        = (is_signed_op && bus.b[WIDTH-1]) ? -bus.b : bus.b;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt  = state;
      accept     = 1'b0;
      short_path = op_illegal || div_zero;
      case (state)
         S_IDLE, S_DONE: begin
            state_nxt = S_IDLE;
            if (bus.start) begin
               accept    = 1'b1;
               state_nxt = short_path ? S_DONE : S_RUN;
            end
         end
         S_RUN:   if (cnt == CNT_W'(1)) state_nxt = S_FIX;
         S_FIX:   state_nxt = S_DONE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      rem_sh = {rem, quot[WIDTH-1]};
      trial  = rem_sh - {1'b0, dvsr};
      // Upper half of the negated product: only a zero lower half carries in.
      smulh_hi = ~prod[2*WIDTH-1:WIDTH] +
                 {{(WIDTH-1){1'b0}}, (prod[WIDTH-1:0] == '0)};
      case (op_q)
         OP_MUL:   fix_result = prod[WIDTH-1:0];
         OP_UMULH: fix_result = prod[2*WIDTH-1:WIDTH];
         OP_SMULH: fix_result = neg_q ? smulh_hi : prod[2*WIDTH-1:WIDTH];
         OP_UDIV:  fix_result = quot;
         OP_SDIV:  fix_result = neg_q ? -quot : quot;
         default:  fix_result = '0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q     <= '0;
         neg_q    <= 1'b0;
         cnt      <= '0;
         mcand    <= '0;
         prod     <= '0;
         mplier   <= '0;
         rem      <= '0;
         quot     <= '0;
         dvsr     <= '0;
         result_q <= '0;
         dbz_q    <= 1'b0;
      end else if (accept) begin
         op_q   <= bus.op;
         neg_q  <= is_signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
         cnt    <= CNT_W'(WIDTH);
         mcand  <= {{WIDTH{1'b0}}, a_mag};
         prod   <= '0;
         mplier <= b_mag;
         rem    <= '0;
         quot   <= a_mag;
         dvsr   <= b_mag;
         dbz_q  <= div_zero;
         if (short_path) result_q <= '0;
      end else if (state == S_RUN) begin
         // Multiply and divide datapaths both step; op_q picks one at FIX.
         cnt    <= cnt - CNT_W'(1);
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
         if (mplier[0]) prod <= prod + mcand;
         if (!trial[WIDTH]) begin
            rem  <= trial[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b1};
         end else begin
            rem  <= rem_sh[WIDTH-1:0];
            quot <= {quot[WIDTH-2:0], 1'b0};
         end
      end else if (state == S_FIX) begin
         result_q <= fix_result;
      end
   end

   assign bus.busy        = (state == S_RUN) || (state == S_FIX);
   assign bus.done        = (state == S_DONE);
   assign bus.result      = result_q;
   assign bus.div_by_zero = dbz_q;

endmodule
